fetch_sequencer: RTL and testbench

- Dual-issue fetch controller; owns the architectural fetch PC and drives the two-slot fetch stage.
- Each cycle it selects the fetch mode: both slots from a new PC pair, a single-slot shift, or a hold.
- Tracks the PCs latched into the fetch/decode register and handles mispredict redirects and the post-reset boot sequence.
- Sits between the fetch stage, the decode/hazard unit and the execute-stage branch resolver.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_pc_next.sv | 43 ++++
 rtl/fetch_sequencer.sv | 100 ++++++++++
 tb/tb_fetch_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state/mode encodings and fetch constants for the dual-issue fetch sequencer.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int PAIR_BYTES = 8;
  localparam logic [14:0] DEF_RESET_PC = 15'h0000;
  typedef enum logic [1:0] {FS_RST, FS_BOOT, FS_RUN} fetch_state_e;
  typedef enum logic [1:0] {M_HOLD, M_REDIR, M_SINGLE, M_DUAL} fetch_mode_e;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: priority selector (redirect > stall > single shift > dual advance) for the next fetch PC and F/D pair.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int PC_W = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            boot_i,
  input  logic            run_i,
  input  logic            stall_i,
  input  logic            issue_single_i,
  input  logic            ex_miss_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  input  logic [PC_W-1:0] fd_pc1_i,
  input  logic [PC_W-1:0] fd_pc2_i,
  output logic            w_miss_o,
  output logic            next_is_single_o,
  output logic [PC_W-1:0] pc_in1_o,
  output logic [PC_W-1:0] pc_in2_o,
  output logic [PC_W-1:0] fetch_pc_d_o,
  output logic [PC_W-1:0] fd_pc1_d_o,
  output logic [PC_W-1:0] fd_pc2_d_o,
  output fetch_mode_e     mode_o
);
  always_comb begin
    w_miss_o         = run_i & ex_miss_i;
    next_is_single_o = run_i & issue_single_i & ~stall_i & ~w_miss_o;
    pc_in1_o         = boot_i ? RESET_PC : w_miss_o ? ex_target_i : fetch_pc_i;
    pc_in2_o         = pc_in1_o + PC_W'(INSTR_BYTES);
    // BOOT always forces a fresh pair, so stall only matters once running
    mode_o           = !(boot_i | run_i)   ? M_HOLD   :
                       w_miss_o            ? M_REDIR  :
                       (run_i & stall_i)   ? M_HOLD   :
                       next_is_single_o    ? M_SINGLE : M_DUAL;
    fd_pc1_d_o       = mode_o == M_SINGLE ? fd_pc2_i :
                       mode_o == M_HOLD   ? fd_pc1_i : pc_in1_o;
    fd_pc2_d_o       = mode_o == M_SINGLE ? fetch_pc_i :
                       mode_o == M_HOLD   ? fd_pc2_i : pc_in2_o;
    fetch_pc_d_o     = mode_o == M_SINGLE ? fetch_pc_i + PC_W'(INSTR_BYTES) :
                       mode_o == M_HOLD   ? fetch_pc_i : pc_in1_o + PC_W'(PAIR_BYTES);
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: dual-issue fetch controller owning the fetch PC, F/D pair PCs, redirects and boot sequence.
// Optional FETCH_SEQ_PERF_EN adds saturating dual/single/redirect event counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W = 15,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            issue_single,
  input  logic            ex_miss,
  input  logic [PC_W-1:0] ex_target,
  output logic            w_miss,
  output logic            next_is_single,
  output logic [PC_W-1:0] pc_in1,
  output logic [PC_W-1:0] pc_in2,
  output logic [PC_W-1:0] F_D_pc1,
  output logic [PC_W-1:0] F_D_pc2,
  output logic [1:0]      fd_valid,
  output logic            kill_fd
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_dual,
  output logic [31:0]     perf_single,
  output logic [31:0]     perf_redirect
`endif
);
  fetch_state_e state_q, state_d;
  fetch_mode_e mode;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, fd_pc1_q, fd_pc1_d, fd_pc2_q, fd_pc2_d;
  logic [1:0] fd_valid_q, fd_valid_d;

  fetch_pc_next #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_next (
    .boot_i          (state_q == FS_BOOT),
    .run_i           (state_q == FS_RUN),
    .stall_i         (stall),
    .issue_single_i  (issue_single),
    .ex_miss_i       (ex_miss),
    .ex_target_i     (ex_target),
    .fetch_pc_i      (fetch_pc_q),
    .fd_pc1_i        (fd_pc1_q),
    .fd_pc2_i        (fd_pc2_q),
    .w_miss_o        (w_miss),
    .next_is_single_o(next_is_single),
    .pc_in1_o        (pc_in1),
    .pc_in2_o        (pc_in2),
    .fetch_pc_d_o    (fetch_pc_d),
    .fd_pc1_d_o      (fd_pc1_d),
    .fd_pc2_d_o      (fd_pc2_d),
    .mode_o          (mode)
  );

  always_comb begin
    state_d    = state_q == FS_RST ? FS_BOOT : FS_RUN;
    fd_valid_d = mode == M_HOLD ? fd_valid_q : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FS_RST;
      fetch_pc_q <= RESET_PC;
      fd_pc1_q   <= '0;
      fd_pc2_q   <= '0;
      fd_valid_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fd_pc1_q   <= fd_pc1_d;
      fd_pc2_q   <= fd_pc2_d;
      fd_valid_q <= fd_valid_d;
    end
  end

  assign F_D_pc1  = fd_pc1_q;
  assign F_D_pc2  = fd_pc2_q;
  assign fd_valid = fd_valid_q;
  assign kill_fd  = w_miss;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] cnt_dual_q, cnt_single_q, cnt_redirect_q;
  logic run;
  assign run = state_q == FS_RUN;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_dual_q     <= '0;
      cnt_single_q   <= '0;
      cnt_redirect_q <= '0;
    end else begin
      if (run && mode == M_DUAL && cnt_dual_q != '1) cnt_dual_q <= cnt_dual_q + 32'd1;
      if (run && mode == M_SINGLE && cnt_single_q != '1) cnt_single_q <= cnt_single_q + 32'd1;
      if (run && mode == M_REDIR && cnt_redirect_q != '1) cnt_redirect_q <= cnt_redirect_q + 32'd1;
    end
  end
  assign perf_dual     = cnt_dual_q;
  assign perf_single   = cnt_single_q;
  assign perf_redirect = cnt_redirect_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations, checked through a scoreboard queue.
module tb_fetch_sequencer;
  logic clk, reset, stall, issue_single, ex_miss;
  logic [14:0] ex_target, pc_in1, pc_in2, F_D_pc1, F_D_pc2;
  logic w_miss, next_is_single, kill_fd;
  logic [1:0] fd_valid;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_dual, perf_single, perf_redirect;
`endif

  fetch_sequencer #(.PC_W(15), .RESET_PC(15'h0100)) dut (
    .clk(clk), .reset(reset), .stall(stall), .issue_single(issue_single),
    .ex_miss(ex_miss), .ex_target(ex_target), .w_miss(w_miss),
    .next_is_single(next_is_single), .pc_in1(pc_in1), .pc_in2(pc_in2),
    .F_D_pc1(F_D_pc1), .F_D_pc2(F_D_pc2), .fd_valid(fd_valid), .kill_fd(kill_fd)
`ifdef FETCH_SEQ_PERF_EN
    , .perf_dual(perf_dual), .perf_single(perf_single), .perf_redirect(perf_redirect)
`endif
  );

  typedef struct {
    logic [14:0] p1, p2, pc;
    logic [1:0]  v;
    logic        wm, nis;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("F_D_pc1", 32'(F_D_pc1), 32'(e.p1));
      chk("F_D_pc2", 32'(F_D_pc2), 32'(e.p2));
      chk("fd_valid", 32'(fd_valid), 32'(e.v));
      chk("w_miss", 32'(w_miss), 32'(e.wm));
      chk("kill_fd", 32'(kill_fd), 32'(e.wm));
      chk("next_is_single", 32'(next_is_single), 32'(e.nis));
      chk("pc_in1", 32'(pc_in1), 32'(e.pc));
      chk("pc_in2", 32'(pc_in2), 32'(15'(e.pc + 15'd4)));
    end
  end

  // drive one cycle of inputs and queue what the DUT should show during that cycle
  task automatic step(input logic r, st, si, em, input logic [14:0] et,
                      input logic [14:0] e1, e2, input logic [1:0] ev,
                      input logic ewm, enis, input logic [14:0] epc);
    exp_t e;
    reset = r; stall = st; issue_single = si; ex_miss = em; ex_target = et;
    e.p1 = e1; e.p2 = e2; e.v = ev; e.wm = ewm; e.nis = enis; e.pc = epc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; stall = 0; issue_single = 0; ex_miss = 0; ex_target = '0;
    @(posedge clk);
    #1;
    //   r  st si em target    F_D_pc1   F_D_pc2   v      wm nis pc_in1
    step(0, 0, 1, 1, 15'h0400, 15'h0000, 15'h0000, 2'b00, 0, 0, 15'h0100); // RST ignores miss
    step(1, 0, 0, 0, 15'h0000, 15'h0000, 15'h0000, 2'b00, 0, 0, 15'h0100); // RST -> BOOT
    step(1, 1, 1, 1, 15'h0400, 15'h0000, 15'h0000, 2'b00, 0, 0, 15'h0100); // BOOT ignores miss/stall
    step(1, 0, 0, 0, 15'h0000, 15'h0100, 15'h0104, 2'b11, 0, 0, 15'h0108);
    step(1, 0, 0, 0, 15'h0000, 15'h0108, 15'h010C, 2'b11, 0, 0, 15'h0110);
    step(1, 0, 0, 1, 15'h0200, 15'h0110, 15'h0114, 2'b11, 1, 0, 15'h0200);
    step(1, 0, 1, 0, 15'h0000, 15'h0200, 15'h0204, 2'b11, 0, 1, 15'h0208); // single shift
    step(1, 0, 0, 0, 15'h0000, 15'h0204, 15'h0208, 2'b11, 0, 0, 15'h020C);
    step(1, 1, 1, 0, 15'h0000, 15'h020C, 15'h0210, 2'b11, 0, 0, 15'h0214); // stall x3
    step(1, 1, 1, 0, 15'h0000, 15'h020C, 15'h0210, 2'b11, 0, 0, 15'h0214);
    step(1, 1, 1, 0, 15'h0000, 15'h020C, 15'h0210, 2'b11, 0, 0, 15'h0214);
    step(1, 1, 1, 1, 15'h0400, 15'h020C, 15'h0210, 2'b11, 1, 0, 15'h0400); // miss beats stall+single
    step(1, 0, 0, 0, 15'h0000, 15'h0400, 15'h0404, 2'b11, 0, 0, 15'h0408);
    step(1, 0, 0, 1, 15'h7FF0, 15'h0408, 15'h040C, 2'b11, 1, 0, 15'h7FF0);
    step(1, 0, 0, 0, 15'h0000, 15'h7FF0, 15'h7FF4, 2'b11, 0, 0, 15'h7FF8);
    step(1, 0, 0, 0, 15'h0000, 15'h7FF8, 15'h7FFC, 2'b11, 0, 0, 15'h0000); // wrap
    step(1, 0, 1, 0, 15'h0000, 15'h0000, 15'h0004, 2'b11, 0, 1, 15'h0008);
    step(1, 0, 0, 1, 15'h0300, 15'h0004, 15'h0008, 2'b11, 1, 0, 15'h0300);
    step(0, 0, 0, 1, 15'h0500, 15'h0300, 15'h0304, 2'b11, 1, 0, 15'h0500); // reset after miss
    step(1, 0, 0, 1, 15'h0500, 15'h0000, 15'h0000, 2'b00, 0, 0, 15'h0100);
    step(1, 0, 0, 1, 15'h0600, 15'h0000, 15'h0000, 2'b00, 0, 0, 15'h0100);
    step(1, 0, 0, 0, 15'h0000, 15'h0100, 15'h0104, 2'b11, 0, 0, 15'h0108);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
